// File: rtl/fifo_wr_arb_if.sv
// fifo_wr_arb_if: requester beats, FIFO write port and status between a writer and the arbiter.
interface fifo_wr_arb_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 32,
  parameter int DEPTH = 64
);
  logic [N_REQ-1:0]       req_valid_i;
  logic [N_REQ*WIDTH-1:0] req_data_i;
  logic [N_REQ-1:0]       req_last_i;
  logic [N_REQ-1:0]       req_ready_o;
  logic [N_REQ-1:0]       gnt_o;
  logic                   fifo_wr_en_o;
  logic [WIDTH-1:0]       fifo_wr_data_o;
  logic                   fifo_wr_full_i;
  logic [$clog2(DEPTH):0] fifo_wr_free_i;
  logic                   err_o;
  modport slave (
    input  req_valid_i, req_data_i, req_last_i, fifo_wr_full_i, fifo_wr_free_i,
    output req_ready_o, gnt_o, fifo_wr_en_o, fifo_wr_data_o, err_o
  );
  modport master (
    output req_valid_i, req_data_i, req_last_i, fifo_wr_full_i, fifo_wr_free_i,
    input  req_ready_o, gnt_o, fifo_wr_en_o, fifo_wr_data_o, err_o
  );
endinterface

// File: rtl/fifo_wr_arb.sv
// fifo_wr_arb: round-robin burst arbiter funnelling N_REQ requesters into one FIFO write port.
module fifo_wr_arb #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 32,
  parameter int DEPTH = 64,
  parameter int BURST = 8
) (
  input logic          clk_i,
  input logic          rst_i,
  fifo_wr_arb_if.slave bus
);
  localparam int SW = $clog2(N_REQ);
  localparam int CW = $clog2(BURST + 1);
  localparam int FW = $clog2(DEPTH) + 1;
  typedef enum logic {S_IDLE, S_BURST} state_t;
  state_t           r_state, w_next;
  logic [SW-1:0]    r_ptr, r_sel, w_win, w_win_nxt;
  logic [CW-1:0]    r_cnt;
  logic [N_REQ-1:0] r_gnt;
  logic             r_err;
  logic             w_start, w_acc, w_last, w_cnt_end, w_end;
  logic [WIDTH-1:0] w_data;

  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) r_state <= S_IDLE;
    else r_state <= w_next;

  // Offsets are scanned high to low so the smallest offset from r_ptr wins.
  always_comb begin
    w_win = '0;
    w_win_nxt = '0;
    for (int i = N_REQ - 1; i >= 0; i--)
      if (bus.req_valid_i[SW'((int'(r_ptr) + i) % N_REQ)]) begin
        w_win = SW'((int'(r_ptr) + i) % N_REQ);
        w_win_nxt = SW'((int'(r_ptr) + i + 1) % N_REQ);
      end
    w_start = |bus.req_valid_i && bus.fifo_wr_free_i >= FW'(BURST);
    w_cnt_end = r_cnt == CW'(BURST - 1);
    w_end = w_acc && (w_last || w_cnt_end);
    w_next = r_state == S_IDLE ? (w_start ? S_BURST : S_IDLE) : (w_end ? S_IDLE : S_BURST);
  end

  always_comb begin
    w_data = '0;
    for (int k = 0; k < N_REQ; k++)
      if (r_sel == SW'(k)) w_data = bus.req_data_i[k*WIDTH +: WIDTH];
    w_last = bus.req_last_i[r_sel];
    w_acc = r_state == S_BURST && bus.req_valid_i[r_sel] && !bus.fifo_wr_full_i;
    bus.fifo_wr_en_o = w_acc;
    bus.fifo_wr_data_o = w_acc ? w_data : '0;
    bus.req_ready_o = w_acc ? N_REQ'(1) << r_sel : '0;
    bus.gnt_o = r_gnt;
    bus.err_o = r_err;
  end

  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      r_ptr <= '0;
      r_sel <= '0;
      r_cnt <= '0;
      r_gnt <= '0;
      r_err <= 1'b0;
    end else if (r_state == S_IDLE && w_start) begin
      r_sel <= w_win;
      r_ptr <= w_win_nxt;
      r_gnt <= N_REQ'(1) << w_win;
      r_cnt <= '0;
    end else if (w_acc) begin
      r_cnt <= r_cnt + 1'b1;
      if (w_end) r_gnt <= '0;
      if (w_cnt_end && !w_last) r_err <= 1'b1;
    end
endmodule

// File: tb/tb_fifo_wr_arb.sv
// tb_fifo_wr_arb: directed checks of grant order, burst termination, stalls, error flag and reset abort.
module tb_fifo_wr_arb;
  logic clk_i = 1'b0;
  logic rst_i;
  int   n_cmp = 0;
  int   n_err = 0;

  fifo_wr_arb_if #(.N_REQ(4), .WIDTH(32), .DEPTH(64)) bus ();
  fifo_wr_arb #(.N_REQ(4), .WIDTH(32), .DEPTH(64), .BURST(8)) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .bus  (bus)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_i = 1'b1;
    bus.req_valid_i = '0;
    bus.req_last_i = '0;
    bus.req_data_i = '0;
    bus.fifo_wr_full_i = 1'b0;
    bus.fifo_wr_free_i = 7'd64;
    #1;
    chk("rst_gnt", bus.gnt_o, 0);
    chk("rst_ready", bus.req_ready_o, 0);
    chk("rst_en", bus.fifo_wr_en_o, 0);
    chk("rst_data", bus.fifo_wr_data_o, 0);
    chk("rst_err", bus.err_o, 0);
    tick();
    tick();
    rst_i = 1'b0;
    // single requester, three beats
    bus.req_data_i[31:0] = 32'hA0;
    bus.req_valid_i = 4'b0001;
    #1;
    chk("t1_idle_gnt", bus.gnt_o, 0);
    chk("t1_idle_en", bus.fifo_wr_en_o, 0);
    chk("t1_idle_data", bus.fifo_wr_data_o, 0);
    tick();
    chk("t1_gnt", bus.gnt_o, 4'b0001);
    chk("t1_b0_en", bus.fifo_wr_en_o, 1);
    chk("t1_b0_data", bus.fifo_wr_data_o, 32'hA0);
    chk("t1_b0_ready", bus.req_ready_o, 4'b0001);
    tick();
    bus.req_data_i[31:0] = 32'hA1;
    #1;
    chk("t1_b1_en", bus.fifo_wr_en_o, 1);
    chk("t1_b1_data", bus.fifo_wr_data_o, 32'hA1);
    tick();
    bus.req_data_i[31:0] = 32'hA2;
    bus.req_last_i = 4'b0001;
    #1;
    chk("t1_b2_en", bus.fifo_wr_en_o, 1);
    chk("t1_b2_data", bus.fifo_wr_data_o, 32'hA2);
    chk("t1_b2_gnt", bus.gnt_o, 4'b0001);
    tick();
    bus.req_valid_i = '0;
    bus.req_last_i = '0;
    #1;
    chk("t1_end_gnt", bus.gnt_o, 0);
    chk("t1_end_en", bus.fifo_wr_en_o, 0);
    chk("t1_end_ptr", dut.r_ptr, 1);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    #1;
    chk("rst2_ptr", dut.r_ptr, 0);
    // all four valid, two-beat bursts
    bus.req_data_i = {32'hD3, 32'hD2, 32'hD1, 32'hD0};
    bus.req_valid_i = 4'b1111;
    for (int b = 0; b < 5; b++) begin
      #1;
      chk("t2_bubble_gnt", bus.gnt_o, 0);
      chk("t2_bubble_en", bus.fifo_wr_en_o, 0);
      tick();
      chk("t2_gnt", bus.gnt_o, 64'd1 << (b % 4));
      chk("t2_b0_data", bus.fifo_wr_data_o, 64'hD0 + 64'(b % 4));
      tick();
      bus.req_last_i = 4'(1 << (b % 4));
      #1;
      chk("t2_b1_en", bus.fifo_wr_en_o, 1);
      chk("t2_b1_ready", bus.req_ready_o, 64'd1 << (b % 4));
      tick();
      bus.req_last_i = '0;
    end
    bus.req_valid_i = '0;
    #1;
    chk("t2_end_gnt", bus.gnt_o, 0);
    chk("t2_end_ptr", dut.r_ptr, 1);
    // free-space threshold
    bus.req_valid_i = 4'b0100;
    bus.fifo_wr_free_i = 7'd7;
    #1;
    tick();
    chk("t3_free7_gnt_a", bus.gnt_o, 0);
    tick();
    chk("t3_free7_gnt_b", bus.gnt_o, 0);
    bus.fifo_wr_free_i = 7'd8;
    #1;
    chk("t3_free8_gnt_now", bus.gnt_o, 0);
    tick();
    chk("t3_free8_gnt", bus.gnt_o, 4'b0100);
    chk("t3_data", bus.fifo_wr_data_o, 32'hD2);
    bus.req_last_i = 4'b0100;
    tick();
    bus.req_valid_i = '0;
    bus.req_last_i = '0;
    bus.fifo_wr_free_i = 7'd64;
    #1;
    chk("t3_end_gnt", bus.gnt_o, 0);
    // FIFO full stall
    bus.req_data_i[31:0] = 32'h55;
    bus.req_valid_i = 4'b0001;
    #1;
    tick();
    chk("t4_gnt", bus.gnt_o, 4'b0001);
    chk("t4_b0_data", bus.fifo_wr_data_o, 32'h55);
    tick();
    bus.req_data_i[31:0] = 32'h66;
    bus.fifo_wr_full_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t4_full_en", bus.fifo_wr_en_o, 0);
      chk("t4_full_ready", bus.req_ready_o, 0);
      chk("t4_full_data", bus.fifo_wr_data_o, 0);
      chk("t4_full_gnt", bus.gnt_o, 4'b0001);
      tick();
    end
    bus.fifo_wr_full_i = 1'b0;
    bus.req_last_i = 4'b0001;
    #1;
    chk("t4_resume_en", bus.fifo_wr_en_o, 1);
    chk("t4_resume_data", bus.fifo_wr_data_o, 32'h66);
    chk("t4_resume_ready", bus.req_ready_o, 4'b0001);
    tick();
    bus.req_valid_i = '0;
    bus.req_last_i = '0;
    #1;
    chk("t4_end_gnt", bus.gnt_o, 0);
    // over-length burst
    bus.req_valid_i = 4'b0010;
    #1;
    tick();
    for (int i = 0; i < 8; i++) begin
      chk("t5_en", bus.fifo_wr_en_o, 1);
      chk("t5_gnt", bus.gnt_o, 4'b0010);
      chk("t5_err_pre", bus.err_o, 0);
      tick();
    end
    bus.req_valid_i = '0;
    #1;
    chk("t5_end_gnt", bus.gnt_o, 0);
    chk("t5_end_en", bus.fifo_wr_en_o, 0);
    chk("t5_err", bus.err_o, 1);
    tick();
    tick();
    chk("t5_err_sticky", bus.err_o, 1);
    // reset mid-burst
    bus.req_valid_i = 4'b1010;
    #1;
    tick();
    chk("t6_gnt", bus.gnt_o, 4'b1000);
    tick();
    tick();
    chk("t6_b2_en", bus.fifo_wr_en_o, 1);
    rst_i = 1'b1;
    #1;
    chk("t6_rst_gnt", bus.gnt_o, 0);
    chk("t6_rst_en", bus.fifo_wr_en_o, 0);
    chk("t6_rst_ready", bus.req_ready_o, 0);
    chk("t6_rst_data", bus.fifo_wr_data_o, 0);
    chk("t6_rst_err", bus.err_o, 0);
    chk("t6_rst_ptr", dut.r_ptr, 0);
    tick();
    rst_i = 1'b0;
    #1;
    chk("t6_post_gnt", bus.gnt_o, 0);
    chk("t6_post_en", bus.fifo_wr_en_o, 0);
    tick();
    chk("t6_regrant", bus.gnt_o, 4'b0010);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
